keypad_scanner: RTL and testbench

//  Scans a 4x3 membrane keypad matrix, debounces it and produces the operator

---
 rtl/keypad_scanner.sv | 214 +++++++++++++++++++++
 tb/tb_keypad_scanner.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// 4x3 keypad matrix scanner with frame-based debounce feeding the microwave operator interface.
// Optional KPD_STROBE_EN adds key_strobe, a one-cycle pulse on each fresh key acceptance.
`timescale 1ns/1ps

module keypad_scanner #(
    parameter int SCAN_DIV = 4,
    parameter int DEBOUNCE = 3
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [2:0] col_n,
    output logic [3:0] row_n,
    output logic [9:0] kbd,
    output logic       startn,
    output logic       clearn,
    output logic       key_valid
`ifdef KPD_STROBE_EN
    ,
    output logic       key_strobe
`endif
);

    localparam int DW_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CNT_W = (DEBOUNCE > 0) ? $clog2(DEBOUNCE + 1) : 1;
    localparam logic [DW_W-1:0]  DW_LAST  = DW_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE);

    typedef enum logic [1:0] {
        S_RELEASED,
        S_CANDIDATE,
        S_PRESSED,
        S_RELEASING
    } state_t;

    logic [DW_W-1:0]  r_dwell;
    logic [1:0]       r_row;
    logic [8:0]       r_acc;
    state_t           r_state;
    logic [3:0]       r_cand;
    logic [3:0]       r_held;
    logic [CNT_W-1:0] r_cnt;
    logic [9:0]       r_kbd;
    logic             r_startn;
    logic             r_clearn;
    logic             r_valid;

    logic             w_sample;
    logic             w_frame_end;
    logic [11:0]      w_keys;
    logic [3:0]       w_nkeys;
    logic [3:0]       w_key_idx;
    logic             w_single;
    state_t           w_state_nxt;
    logic [3:0]       w_cand_nxt;
    logic [3:0]       w_held_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_active_nxt;

    // col_n is only trusted on the last dwell cycle of a row, after the lines have settled.
    assign w_sample    = (r_dwell == DW_LAST);
    assign w_frame_end = w_sample && (r_row == 2'd3);

    // NOTE: synchronous active-low reset; every register, including the sample buffer, is cleared.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_dwell <= '0;
            r_row   <= '0;
            r_acc   <= '0;
        end else if (w_sample) begin
            r_dwell <= '0;
            r_row   <= r_row + 2'd1;
            case (r_row)
                2'd0:    r_acc[2:0] <= ~col_n;
                2'd1:    r_acc[5:3] <= ~col_n;
                2'd2:    r_acc[8:6] <= ~col_n;
                default: r_acc      <= r_acc;
            endcase
        end else begin
            r_dwell <= r_dwell + 1'b1;
        end
    end

    assign row_n = ~(4'b0001 << r_row);

    // Row 3 is taken straight from the pins on the frame-end edge; rows 0-2 come from the buffer.
    assign w_keys = {~col_n, r_acc};

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_nkeys   = '0;
        w_key_idx = '0;
        for (int i = 0; i < 12; i++) begin
            if (w_keys[i]) begin
                w_nkeys   = w_nkeys + 4'd1;
                w_key_idx = 4'(i);
            end
        end
    end

    assign w_single = (w_nkeys == 4'd1);

    always_comb begin
        w_state_nxt = r_state;
        w_cand_nxt  = r_cand;
        w_held_nxt  = r_held;
        w_cnt_nxt   = r_cnt;
        if (w_frame_end) begin
            case (r_state)
                S_RELEASED: begin
                    if (w_single) begin
                        if (DEBOUNCE == 1) begin
                            w_state_nxt = S_PRESSED;
                            w_held_nxt  = w_key_idx;
                        end else begin
                            w_state_nxt = S_CANDIDATE;
                            w_cand_nxt  = w_key_idx;
                            w_cnt_nxt   = CNT_W'(1);
                        end
                    end
                end
                S_CANDIDATE: begin
                    if (w_single && (w_key_idx == r_cand)) begin
                        if (r_cnt + 1'b1 == CNT_DONE) begin
                            w_state_nxt = S_PRESSED;
                            w_held_nxt  = r_cand;
                        end else begin
                            w_cnt_nxt = r_cnt + 1'b1;
                        end
                    end else if (w_single) begin
                        w_cand_nxt = w_key_idx;
                        w_cnt_nxt  = CNT_W'(1);
                    end else begin
                        w_state_nxt = S_RELEASED;
                    end
                end
                S_PRESSED: begin
                    if (!(w_single && (w_key_idx == r_held))) begin
                        if (DEBOUNCE == 1) begin
                            w_state_nxt = S_RELEASED;
                        end else begin
                            w_state_nxt = S_RELEASING;
                            w_cnt_nxt   = CNT_W'(1);
                        end
                    end
                end
                default: begin
                    if (w_single && (w_key_idx == r_held)) begin
                        w_state_nxt = S_PRESSED;
                    end else if (r_cnt + 1'b1 == CNT_DONE) begin
                        w_state_nxt = S_RELEASED;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    // A key stays accepted until its release has itself debounced, so RELEASING still drives it.
    assign w_active_nxt = (w_state_nxt == S_PRESSED) || (w_state_nxt == S_RELEASING);

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state  <= S_RELEASED;
            r_cand   <= '0;
            r_held   <= '0;
            r_cnt    <= '0;
            r_kbd    <= '0;
            r_startn <= 1'b1;
            r_clearn <= 1'b1;
            r_valid  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cand   <= w_cand_nxt;
            r_held   <= w_held_nxt;
            r_cnt    <= w_cnt_nxt;
            r_kbd    <= '0;
            r_startn <= 1'b1;
            r_clearn <= 1'b1;
            r_valid  <= w_active_nxt;
            if (w_active_nxt) begin
                case (w_held_nxt)
                    4'd9:    r_clearn <= 1'b0;
                    4'd10:   r_kbd    <= 10'd1;
                    4'd11:   r_startn <= 1'b0;
                    default: r_kbd    <= 10'd1 << (w_held_nxt + 4'd1);
                endcase
            end
        end
    end

    assign kbd       = r_kbd;
    assign startn    = r_startn;
    assign clearn    = r_clearn;
    assign key_valid = r_valid;

`ifdef KPD_STROBE_EN
    logic r_strobe;

    // Fires only on a fresh accept, not when a bouncing release falls back into PRESSED.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_strobe <= 1'b0;
        end else begin
            r_strobe <= w_frame_end && (w_state_nxt == S_PRESSED) &&
                        ((r_state == S_RELEASED) || (r_state == S_CANDIDATE));
        end
    end

    assign key_strobe = r_strobe;
`endif

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: models the key matrix from row_n and scoreboards
// per-frame expected outputs. Define KPD_STROBE_EN to also check key_strobe pulses.
`timescale 1ns/1ps

module tb_keypad_scanner;

    typedef struct packed {
        logic [9:0] kbd;
        logic       startn;
        logic       clearn;
        logic       valid;
    } out_t;

    localparam out_t IDLE = '{kbd: 10'd0, startn: 1'b1, clearn: 1'b1, valid: 1'b0};
    localparam int K1 = 0, K2 = 1, K5 = 4, K9 = 8, KSTAR = 9, KHASH = 11;

    logic        clk;
    logic        resetn;
    logic [2:0]  col_n;
    logic [3:0]  row_n;
    logic [9:0]  kbd;
    logic        startn;
    logic        clearn;
    logic        key_valid;
    logic [11:0] keys;

    out_t        sb_q[$];
    logic [3:0]  row_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          strobe_cnt = 0;

`ifdef KPD_STROBE_EN
    logic key_strobe;
`endif

    keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE(3)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .col_n     (col_n),
        .row_n     (row_n),
        .kbd       (kbd),
        .startn    (startn),
        .clearn    (clearn),
        .key_valid (key_valid)
`ifdef KPD_STROBE_EN
        ,
        .key_strobe(key_strobe)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Matrix model: a held key pulls its column low while its row is driven.
    always_comb begin
        col_n = 3'b111;
        for (int r = 0; r < 4; r++) begin
            if (!row_n[r]) begin
                for (int c = 0; c < 3; c++) begin
                    if (keys[r*3 + c]) col_n[c] = 1'b0;
                end
            end
        end
    end

`ifdef KPD_STROBE_EN
    always @(negedge clk) begin
        if (key_strobe === 1'b1) strobe_cnt++;
    end
`endif

    function automatic out_t digit_out(input int d);
        out_t o;
        o       = IDLE;
        o.kbd   = 10'd1 << d;
        o.valid = 1'b1;
        return o;
    endfunction

    function automatic out_t ctrl_out(input logic is_start);
        out_t o;
        o        = IDLE;
        o.startn = ~is_start;
        o.clearn = is_start;
        o.valid  = 1'b1;
        return o;
    endfunction

    function automatic logic [11:0] key_bit(input int k);
        return 12'd1 << k;
    endfunction

    task automatic test_reset();
        out_t obs, want;
        logic [3:0] row_want;
        logic [3:0] row_seq [4];
        row_seq = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
        keys   = '0;
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        sb_q.push_back(IDLE);
        row_q.push_back(4'b1110);
        want = sb_q.pop_front();
        obs  = out_t'({kbd, startn, clearn, key_valid});
        n_vec++;
        if (obs !== want) begin
            n_err++;
            $display("FAIL reset_outputs: got %b want %b", obs, want);
        end
        row_want = row_q.pop_front();
        n_vec++;
        if (row_n !== row_want) begin
            n_err++;
            $display("FAIL reset_row_n: got %b want %b", row_n, row_want);
        end
        resetn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            row_q.push_back(row_seq[i]);
            repeat (4) @(posedge clk);
            #1;
            row_want = row_q.pop_front();
            n_vec++;
            if (row_n !== row_want) begin
                n_err++;
                $display("FAIL row_step%0d: got %b want %b", i, row_n, row_want);
            end
        end
    endtask

    task automatic test_single_key();
        out_t obs, want;
        int   s0;
        s0 = strobe_cnt;
        for (int f = 1; f <= 13; f++) begin
            keys = (f <= 10) ? key_bit(K5) : '0;
            sb_q.push_back((f >= 3 && f <= 12) ? digit_out(5) : IDLE);
            repeat (16) @(posedge clk);
            #1;
            want = sb_q.pop_front();
            obs  = out_t'({kbd, startn, clearn, key_valid});
            n_vec++;
            if (obs !== want) begin
                n_err++;
                $display("FAIL single_key f%0d: got %b want %b", f, obs, want);
            end
        end
`ifdef KPD_STROBE_EN
        n_vec++;
        if (strobe_cnt - s0 !== 1) begin
            n_err++;
            $display("FAIL strobe_single_key: got %0d pulse cycles want 1", strobe_cnt - s0);
        end
`endif
    endtask

    task automatic test_bounce();
        out_t obs, want;
        logic [6:0] pattern;
        pattern = 7'b0011011;
        for (int f = 1; f <= 7; f++) begin
            keys = pattern[f-1] ? key_bit(K2) : '0;
            sb_q.push_back(IDLE);
            repeat (16) @(posedge clk);
            #1;
            want = sb_q.pop_front();
            obs  = out_t'({kbd, startn, clearn, key_valid});
            n_vec++;
            if (obs !== want) begin
                n_err++;
                $display("FAIL bounce f%0d: got %b want %b", f, obs, want);
            end
        end
    endtask

    task automatic test_control_keys();
        out_t obs, want;
        for (int f = 1; f <= 16; f++) begin
            if (f <= 5)                keys = key_bit(KHASH);
            else if (f >= 9 && f <= 13) keys = key_bit(KSTAR);
            else                       keys = '0;
            if (f >= 3 && f <= 7)        sb_q.push_back(ctrl_out(1'b1));
            else if (f >= 11 && f <= 15) sb_q.push_back(ctrl_out(1'b0));
            else                         sb_q.push_back(IDLE);
            repeat (16) @(posedge clk);
            #1;
            want = sb_q.pop_front();
            obs  = out_t'({kbd, startn, clearn, key_valid});
            n_vec++;
            if (obs !== want) begin
                n_err++;
                $display("FAIL control_keys f%0d: got %b want %b", f, obs, want);
            end
        end
    endtask

    task automatic test_multi_key();
        out_t obs, want;
        for (int f = 1; f <= 14; f++) begin
            if (f <= 6 || (f >= 11 && f <= 13)) keys = key_bit(K1) | key_bit(K2);
            else if (f >= 8 && f <= 10)         keys = key_bit(K1);
            else                                keys = '0;
            sb_q.push_back((f >= 10 && f <= 12) ? digit_out(1) : IDLE);
            repeat (16) @(posedge clk);
            #1;
            want = sb_q.pop_front();
            obs  = out_t'({kbd, startn, clearn, key_valid});
            n_vec++;
            if (obs !== want) begin
                n_err++;
                $display("FAIL multi_key f%0d: got %b want %b", f, obs, want);
            end
        end
    endtask

    task automatic test_reset_mid_press();
        out_t obs, want;
        int   s0;
        s0 = strobe_cnt;
        for (int f = 1; f <= 4; f++) begin
            keys = key_bit(K9);
            sb_q.push_back((f >= 3) ? digit_out(9) : IDLE);
            repeat (16) @(posedge clk);
            #1;
            want = sb_q.pop_front();
            obs  = out_t'({kbd, startn, clearn, key_valid});
            n_vec++;
            if (obs !== want) begin
                n_err++;
                $display("FAIL pre_reset f%0d: got %b want %b", f, obs, want);
            end
        end
        resetn = 1'b0;
        sb_q.push_back(IDLE);
        @(posedge clk);
        #1;
        want = sb_q.pop_front();
        obs  = out_t'({kbd, startn, clearn, key_valid});
        n_vec++;
        if (obs !== want) begin
            n_err++;
            $display("FAIL reset_mid_press: got %b want %b", obs, want);
        end
        resetn = 1'b1;
        for (int f = 1; f <= 6; f++) begin
            keys = (f <= 3) ? key_bit(K9) : '0;
            sb_q.push_back((f >= 3 && f <= 5) ? digit_out(9) : IDLE);
            repeat (16) @(posedge clk);
            #1;
            want = sb_q.pop_front();
            obs  = out_t'({kbd, startn, clearn, key_valid});
            n_vec++;
            if (obs !== want) begin
                n_err++;
                $display("FAIL post_reset f%0d: got %b want %b", f, obs, want);
            end
        end
`ifdef KPD_STROBE_EN
        n_vec++;
        if (strobe_cnt - s0 !== 2) begin
            n_err++;
            $display("FAIL strobe_reset_mid_press: got %0d pulse cycles want 2", strobe_cnt - s0);
        end
`endif
    endtask

    initial begin
        resetn = 1'b0;
        keys   = '0;
        test_reset();
        test_single_key();
        test_bounce();
        test_control_keys();
        test_multi_key();
        test_reset_mid_press();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
